fill_rect: RTL and testbench
============================

FILL_RECT -- requirements
Module: fill_rect

Interface
REQ-001 Parameter SCREEN_W, default 160, screen width in pixels.
REQ-002 Parameter SCREEN_H, default 120, screen height in pixels.
REQ-003 Parameter X_W, default 8, x coordinate width; SCREEN_W <= 2**X_W.
REQ-004 Parameter Y_W, default 7, y coordinate width; SCREEN_H <= 2**Y_W.
REQ-005 Parameter COLOUR_W, default 3, colour width.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  request; level-held until done seen.
REQ-009 x0, x1  in  X_W each  rectangle corner columns, any order.
REQ-010 y0, y1  in  Y_W each  rectangle corner rows, any order.
REQ-011 colour  in  COLOUR_W  fill colour.
REQ-012 mode  in  1  0 = solid, 1 = stripe.
REQ-013 vga_x  out  X_W  pixel column.
REQ-014 vga_y  out  Y_W  pixel row.
REQ-015 vga_colour  out  COLOUR_W  pixel colour.
REQ-016 vga_plot  out  1  pixel valid strobe.
REQ-017 busy  out  1  high in LOAD or PLOT.
REQ-018 done  out  1  completion flag.

Function
REQ-019 FSM states: IDLE, LOAD, PLOT, DONE.
REQ-020 IDLE->LOAD when start=1; inputs x0,x1,y0,y1,colour,mode sampled on that edge; later input changes ignored.
REQ-021 LOAD (1 cycle): sort corners to x_lo<=x_hi, y_lo<=y_hi; clip x_hi to SCREEN_W-1, y_hi to SCREEN_H-1.
REQ-022 LOAD->DONE directly if x_lo>SCREEN_W-1 or y_lo>SCREEN_H-1 (empty, zero plots); else LOAD->PLOT.
REQ-023 PLOT: one pixel per cycle, vga_plot=1, x outer loop, y inner loop; first pixel (x_lo,y_lo) on the cycle two edges after start sampled.
REQ-024 Scan order: y increments to y_hi, then y returns to y_lo and x increments; after (x_hi,y_hi) go to DONE.
REQ-025 Pixel count exactly (x_hi-x_lo+1)*(y_hi-y_lo+1); no pixel repeated or skipped.
REQ-026 vga_colour = sampled colour in solid mode; = vga_x[COLOUR_W-1:0] in stripe mode (when compiled in).
REQ-027 vga_plot=0 in IDLE, LOAD, DONE; vga_x/vga_y hold last values outside PLOT.
REQ-028 DONE: done=1, held while start=1; DONE->IDLE when start=0; done falls the same edge.
REQ-029 start deasserted during LOAD/PLOT is ignored; operation completes.
REQ-030 A new operation requires start low for at least one cycle (via DONE->IDLE).
REQ-031 Counters internally X_W+1/Y_W+1 bits as needed so corner x_hi=2**X_W-1 terminates without wrap.

Reset
REQ-032 rst asserted at any time: state=IDLE, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0 immediately, no pixel plotted after.
REQ-033 After rst release, start already high begins a new operation on the next edge.

Configuration
REQ-034 Macro FILL_RECT_STRIPE_EN defined: mode input honoured per REQ-026.
REQ-035 Macro undefined: mode ignored, always solid; no stripe logic synthesised.

Structure
REQ-036 Package fill_pkg holds state enum fill_state_t, mode enum fill_mode_t (FILL_SOLID, FILL_STRIPE), default screen constants.
REQ-037 Sub-module rect_clip: combinational sort-and-clip of corners, outputs x_lo,x_hi,y_lo,y_hi,empty.

Verification
REQ-038 Defaults, (0,0)-(159,119), colour 5, solid -> 19200 plots, all colour 5, done=1, then done=0 after start drops.
REQ-039 (12,6)-(10,5), colour 3 -> 6 plots in order (10,5),(10,6),(11,5),(11,6),(12,5),(12,6); first plot two cycles after start.
REQ-040 (150,110)-(200,130) -> clipped to x 150..159, y 110..119, exactly 100 plots.
REQ-041 x0=170,x1=180 -> zero plots, done=1 on second edge after start.
REQ-042 FILL_RECT_STRIPE_EN defined, mode=1, (0,0)-(9,0) -> colours 0..7,0,1 on x=0..9.
REQ-043 rst pulsed after 50 plots of full screen -> vga_plot=0, done=0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/fill_pkg.sv
// Shared types and default screen geometry for the rectangle fill engine.
// The FILL_RECT_STRIPE_EN macro is consumed by fill_rect, not here.
package fill_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLOT = 2'd2,
    S_DONE = 2'd3
  } fill_state_t;

  typedef enum logic {
    FILL_SOLID  = 1'b0,
    FILL_STRIPE = 1'b1
  } fill_mode_t;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_COLOUR_W = 3;

endpackage

// File: rtl/rect_clip.sv
// Combinational corner sort and clip to the visible screen area.
// Flags the rectangle empty when its low corner lies entirely off-screen.
module rect_clip
  import fill_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W
) (
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  output logic [X_W-1:0] x_lo,
  output logic [X_W-1:0] x_hi,
  output logic [Y_W-1:0] y_lo,
  output logic [Y_W-1:0] y_hi,
  output logic           empty
);

  // One extra bit so the limits compare correctly even when SCREEN_W == 2**X_W.
  localparam logic [X_W:0] X_MAX = (X_W+1)'(SCREEN_W - 1);
  localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(SCREEN_H - 1);

  logic [X_W-1:0] x_hi_raw;
  logic [Y_W-1:0] y_hi_raw;

  always_comb begin
    x_lo     = (x0 <= x1) ? x0 : x1;
    x_hi_raw = (x0 <= x1) ? x1 : x0;
    y_lo     = (y0 <= y1) ? y0 : y1;
    y_hi_raw = (y0 <= y1) ? y1 : y0;
    x_hi     = ({1'b0, x_hi_raw} > X_MAX) ? X_MAX[X_W-1:0] : x_hi_raw;
    y_hi     = ({1'b0, y_hi_raw} > Y_MAX) ? Y_MAX[Y_W-1:0] : y_hi_raw;
    empty    = ({1'b0, x_lo} > X_MAX) || ({1'b0, y_lo} > Y_MAX);
  end

endmodule

// File: rtl/fill_rect.sv
// Rectangle fill engine: plots one pixel per cycle, columns outer, rows inner.
// Define FILL_RECT_STRIPE_EN to honour the mode input (colour follows vga_x).
module fill_rect
  import fill_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOUR_W = DEF_COLOUR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y0,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                mode,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done
);

  fill_state_t         state_reg;
  logic [X_W-1:0]      x0_reg, x1_reg, x_hi_reg, vga_x_reg;
  logic [Y_W-1:0]      y0_reg, y1_reg, y_lo_reg, y_hi_reg, vga_y_reg;
  logic [COLOUR_W-1:0] colour_reg;

  logic [X_W-1:0] clip_x_lo, clip_x_hi;
  logic [Y_W-1:0] clip_y_lo, clip_y_hi;
  logic           clip_empty;

  rect_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_clip (
    .x0    (x0_reg),
    .x1    (x1_reg),
    .y0    (y0_reg),
    .y1    (y1_reg),
    .x_lo  (clip_x_lo),
    .x_hi  (clip_x_hi),
    .y_lo  (clip_y_lo),
    .y_hi  (clip_y_hi),
    .empty (clip_empty)
  );

`ifdef FILL_RECT_STRIPE_EN
  fill_mode_t mode_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mode_reg <= FILL_SOLID;
    else if (state_reg == S_IDLE && start)
      mode_reg <= fill_mode_t'(mode);
  end

  assign vga_colour = (mode_reg == FILL_STRIPE) ? vga_x_reg[COLOUR_W-1:0] : colour_reg;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign vga_colour  = colour_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      x0_reg     <= '0;
      x1_reg     <= '0;
      y0_reg     <= '0;
      y1_reg     <= '0;
      colour_reg <= '0;
      x_hi_reg   <= '0;
      y_lo_reg   <= '0;
      y_hi_reg   <= '0;
      vga_x_reg  <= '0;
      vga_y_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            x0_reg     <= x0;
            x1_reg     <= x1;
            y0_reg     <= y0;
            y1_reg     <= y1;
            colour_reg <= colour;
            state_reg  <= S_LOAD;
          end
        end
        S_LOAD: begin
          x_hi_reg <= clip_x_hi;
          y_lo_reg <= clip_y_lo;
          y_hi_reg <= clip_y_hi;
          if (clip_empty) begin
            state_reg <= S_DONE;
          end else begin
            vga_x_reg <= clip_x_lo;
            vga_y_reg <= clip_y_lo;
            state_reg <= S_PLOT;
          end
        end
        S_PLOT: begin
          // Equality termination means x never increments past x_hi, so no wrap.
          if (vga_y_reg == y_hi_reg) begin
            if (vga_x_reg == x_hi_reg) begin
              state_reg <= S_DONE;
            end else begin
              vga_x_reg <= vga_x_reg + X_W'(1);
              vga_y_reg <= y_lo_reg;
            end
          end else begin
            vga_y_reg <= vga_y_reg + Y_W'(1);
          end
        end
        S_DONE: begin
          if (!start)
            state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign vga_x    = vga_x_reg;
  assign vga_y    = vga_y_reg;
  assign vga_plot = (state_reg == S_PLOT);
  assign busy     = (state_reg == S_LOAD) || (state_reg == S_PLOT);
  assign done     = (state_reg == S_DONE);

endmodule

// File: tb/tb_fill_rect.sv
// Scoreboard bench for fill_rect: stimulus queues expected pixels, a negedge
// monitor pops and compares each plotted pixel.
module tb_fill_rect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] x0 = '0, x1 = '0;
  logic [6:0] y0 = '0, y1 = '0;
  logic [2:0] colour = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  logic [17:0] exp_q[$];
  int pass_cnt = 0;
  int chk_cnt  = 0;
  int plot_cnt = 0;

  fill_rect dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x0         (x0),
    .x1         (x1),
    .y0         (y0),
    .y1         (y1),
    .colour     (colour),
    .mode       (mode),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  function automatic logic [17:0] pix(input int x, input int y, input int c);
    return {8'(x), 7'(y), 3'(c)};
  endfunction

  // Monitor: every plotted pixel must match the head of the expected queue.
  always @(negedge clk) begin
    if (vga_plot) begin
      logic [17:0] e;
      plot_cnt++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, required no plot",
                 vga_x, vga_y, vga_colour);
      end else begin
        e = exp_q.pop_front();
        if ({vga_x, vga_y, vga_colour} == e) pass_cnt++;
        else $display("FAIL pixel: got x=%0d y=%0d c=%0d, required x=%0d y=%0d c=%0d",
                      vga_x, vga_y, vga_colour, e[17:10], e[9:3], e[2:0]);
      end
    end
  end

  task automatic launch(input logic [7:0] ax0, input logic [7:0] ax1,
                        input logic [6:0] ay0, input logic [6:0] ay1,
                        input logic [2:0] c, input logic m);
    @(posedge clk); #1;
    x0 = ax0; x1 = ax1; y0 = ay0; y1 = ay1; colour = c; mode = m;
    start = 1'b1;
  endtask

  // Starts with start already high ahead of the sampling edge.
  task automatic finish_op(input string name, input bit empty, input bit drop);
    int waited;
    @(posedge clk); #1;
    check({name, "_busy_load"}, busy, 1);
    check({name, "_plot_load"}, vga_plot, 0);
    if (drop) begin
      start = 1'b0;
      x0 = 8'd99; x1 = 8'd0; y0 = 7'd0; y1 = 7'd99; colour = 3'd0;
    end
    @(posedge clk); #1;
    if (empty) begin
      check({name, "_done_e1"}, done, 1);
      check({name, "_plot_e1"}, vga_plot, 0);
    end else begin
      check({name, "_plot_e1"}, vga_plot, 1);
    end
    waited = 0;
    while (!done && waited < 25000) begin
      @(posedge clk); #1;
      waited++;
    end
    check({name, "_done"}, done, 1);
    check({name, "_drained"}, exp_q.size(), 0);
    if (!drop) begin
      @(posedge clk); #1;
      check({name, "_done_held"}, done, 1);
      start = 1'b0;
    end
    @(posedge clk); #1;
    check({name, "_done_clear"}, done, 0);
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic push_small();
    exp_q.push_back(pix(10, 5, 3));
    exp_q.push_back(pix(10, 6, 3));
    exp_q.push_back(pix(11, 5, 3));
    exp_q.push_back(pix(11, 6, 3));
    exp_q.push_back(pix(12, 5, 3));
    exp_q.push_back(pix(12, 6, 3));
  endtask

  initial begin
    int waited;
    #1;
    check("rst_plot", vga_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pix", int'({vga_x, vga_y, vga_colour}), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Full screen, solid colour 5
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        exp_q.push_back(pix(x, y, 5));
    launch(8'd0, 8'd159, 7'd0, 7'd119, 3'd5, 1'b0);
    finish_op("full", 1'b0, 1'b0);
    check("full_count", plot_cnt, 19200);

    // Swapped corners; start and inputs dropped right after sampling
    push_small();
    launch(8'd12, 8'd10, 7'd6, 7'd5, 3'd3, 1'b0);
    finish_op("small", 1'b0, 1'b1);

    // Clipping; y1 of 130 does not fit Y_W=7, so 127 stands in for off-screen
    plot_cnt = 0;
    for (int x = 150; x < 160; x++)
      for (int y = 110; y < 120; y++)
        exp_q.push_back(pix(x, y, 2));
    launch(8'd150, 8'd200, 7'd110, 7'd127, 3'd2, 1'b0);
    finish_op("clip", 1'b0, 1'b0);
    check("clip_count", plot_cnt, 100);

    // Entirely off-screen to the right, including the maximum column
    plot_cnt = 0;
    launch(8'd170, 8'd180, 7'd0, 7'd0, 3'd1, 1'b0);
    finish_op("empty", 1'b1, 1'b0);
    launch(8'd255, 8'd200, 7'd3, 7'd4, 3'd1, 1'b0);
    finish_op("empty_max", 1'b1, 1'b0);
    check("empty_count", plot_cnt, 0);

    // Stripe request: colour tracks x when compiled in, else stays solid
`ifdef FILL_RECT_STRIPE_EN
    exp_q.push_back(pix(0, 0, 0)); exp_q.push_back(pix(1, 0, 1));
    exp_q.push_back(pix(2, 0, 2)); exp_q.push_back(pix(3, 0, 3));
    exp_q.push_back(pix(4, 0, 4)); exp_q.push_back(pix(5, 0, 5));
    exp_q.push_back(pix(6, 0, 6)); exp_q.push_back(pix(7, 0, 7));
    exp_q.push_back(pix(8, 0, 0)); exp_q.push_back(pix(9, 0, 1));
`else
    for (int x = 0; x < 10; x++) exp_q.push_back(pix(x, 0, 6));
`endif
    launch(8'd0, 8'd9, 7'd0, 7'd0, 3'd6, 1'b1);
    finish_op("stripe", 1'b0, 1'b0);

    // Reset in the middle of a full-screen fill
    plot_cnt = 0;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        exp_q.push_back(pix(x, y, 4));
    launch(8'd0, 8'd159, 7'd0, 7'd119, 3'd4, 1'b0);
    waited = 0;
    while (plot_cnt < 50 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("abort_reached_50", int'(plot_cnt >= 50), 1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("abort_plot", vga_plot, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_pix", int'({vga_x, vga_y, vga_colour}), 0);
    exp_q.delete();

    // Start held high through reset begins a fresh operation on release
    x0 = 8'd12; x1 = 8'd10; y0 = 7'd6; y1 = 7'd5; colour = 3'd3; mode = 1'b0;
    start = 1'b1;
    push_small();
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_busy", busy, 0);
    rst = 1'b0;
    finish_op("restart", 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
